regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single regfile write port between the primary writeback path (ALU/load) and the
//  multi-cycle M-extension unit (MUL/DIV/REM). Keeps a 32-bit busy scoreboard of rd targets
//  with an outstanding M-op, flags RAW/WAW hazards to the decode stage, and prevents starvation.
//  Sits between the writeback sources and regfile (reg_write/rd/wd).
// PARAMETERS
//  STARVE_LIMIT  4   consecutive B-stall cycles before B forced priority (legal 1..15)
// PORTS
//  clk        in   1   sole clock, all state on posedge
//  rst        in   1   asynchronous, active-high reset
//  a_valid    in   1   primary writeback request
//  a_rd       in   5   primary dest register
//  a_data     in   32  primary write data
//  a_ready    out  1   primary request accepted this cycle
//  b_valid    in   1   M-unit result request
//  b_rd       in   5   M-unit dest register
//  b_data     in   32  M-unit result
//  b_ready    out  1   M-unit request accepted this cycle
//  iss_valid  in   1   M-op issuing, reserves iss_rd
//  iss_rd     in   5   dest of issuing M-op
//  iss_ready  out  1   issue accepted (scoreboard updated)
//  chk_rs1    in   5   decode source 1
//  chk_rs2    in   5   decode source 2
//  chk_rd     in   5   decode dest
//  hazard     out  1   decode must stall
//  reg_write  out  1   to regfile write enable
//  rd         out  5   to regfile write address
//  wd         out  32  to regfile write data
//  busy_cnt   out  6   popcount of busy bits (debug)
// BEHAVIOUR
//  - State: busy[31:0], wait_cnt[3:0], force_b flag. All 0 at reset; busy[0] hardwired 0.
//  - rst high: a_ready=b_ready=iss_ready=reg_write=0, hazard=0, busy_cnt=0, rd=0, wd=0.
//  - Arbitration, combinational, zero latency: default A wins. a_ready=a_valid&~force_b;
//    b_ready=b_valid&(force_b|~a_valid). Exactly one source granted per cycle, max.
//  - Write port: granted source drives rd/wd; reg_write=grant&(rd!=0). No grant: reg_write=0,
//    rd=0, wd=0. rd=0 handshakes complete, nothing written.
//  - wait_cnt: +1 each cycle b_valid&~b_ready (saturating at 15); cleared on B accept or
//    b_valid low. force_b registered: set when wait_cnt==STARVE_LIMIT-1 and B still stalled;
//    cleared on B accept. B waits at most STARVE_LIMIT cycles.
//  - Scoreboard: B accept with b_rd!=0 clears busy[b_rd]. iss_ready=iss_valid&~rst&
//    (iss_rd==0 | ~busy[iss_rd] | clearing this cycle). Accepted issue with iss_rd!=0 sets
//    busy[iss_rd]. Same-cycle clear and set, same index: set wins.
//  - hazard=busy[chk_rs1]|busy[chk_rs2]|busy[chk_rd], index 0 contributes 0. Reflects
//    registered busy only, no same-cycle bypass of clears.
//  - A write to a busy rd: decode error prevented by hazard. Arbiter still writes,
//    busy unchanged.
//  - B accept with busy[b_rd]=0: still written (no check).
//  - rst asserted mid-operation: scoreboard and starvation state cleared immediately.
//    Pending M results are the M-unit's responsibility.
//  - busy_cnt=popcount(busy), registered-state view.
// TESTING
//  1 reset: rst=1 with a_valid=b_valid=1 -> reg_write=0, all readies 0, busy_cnt=0.
//  2 priority: a_valid(rd=3,d=0xBA)&b_valid(rd=4,d=5) -> reg_write,rd=3,wd=0xBA,
//    a_ready=1,b_ready=0; next cycle a_valid=0 -> rd=4,wd=5.
//  3 starvation, STARVE_LIMIT=4: a_valid held high, b_valid high ->
//    b_ready=1 on 5th cycle, a_ready=0 that cycle, a resumes next cycle.
//  4 scoreboard: issue rd=7 -> busy_cnt=1, hazard for chk_rs1=7. Second issue rd=7 -> iss_ready=0.
//    B result rd=7 (d=1) with same-cycle issue rd=7 -> write 1, iss_ready=1, busy[7] stays 1.
//  5 x0: issue rd=0 and b_rd=0 -> iss_ready=1, b_ready=1, reg_write=0, busy_cnt=0, chk_rs1=0 -> hazard=0.
//  6 reset mid-op: busy[10] set, rst pulse -> busy_cnt=0, hazard=0 for chk_rs2=10.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter between primary writeback (A) and the M-extension unit (B),
// with a busy scoreboard of outstanding M-op destinations and B anti-starvation.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] wd,
  output logic [5:0]  busy_cnt
);

  localparam logic [3:0] STARVE_TC = 4'(STARVE_LIMIT - 1);

  logic [31:0] busy, busy_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        force_b, force_b_next;
  logic        a_grant, b_grant;
  logic        b_clears_iss;
  logic [5:0]  pop;

  always_comb begin
    a_grant = a_valid & ~force_b & ~rst;
    b_grant = b_valid & (force_b | ~a_valid) & ~rst;
    a_ready = a_grant;
    b_ready = b_grant;
  end

  always_comb begin
    reg_write = 1'b0;
    rd        = 5'd0;
    wd        = 32'd0;
    if (a_grant) begin
      rd        = a_rd;
      wd        = a_data;
      reg_write = (a_rd != 5'd0);
    end else if (b_grant) begin
      rd        = b_rd;
      wd        = b_data;
      reg_write = (b_rd != 5'd0);
    end
  end

  // A clear landing on the same register lets a back-to-back issue through.
  always_comb begin
    b_clears_iss = b_grant & (b_rd == iss_rd);
    iss_ready    = iss_valid & ~rst & ((iss_rd == 5'd0) | ~busy[iss_rd] | b_clears_iss);
  end

  always_comb begin
    busy_next = busy;
    if (b_grant && (b_rd != 5'd0))
      busy_next[b_rd] = 1'b0;
    if (iss_ready && (iss_rd != 5'd0))
      busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    wait_cnt_next = wait_cnt;
    force_b_next  = force_b;
    if (!b_valid || b_grant)
      wait_cnt_next = 4'd0;
    else if (wait_cnt != 4'd15)
      wait_cnt_next = wait_cnt + 4'd1;
    if (b_grant)
      force_b_next = 1'b0;
    else if (b_valid && (wait_cnt == STARVE_TC))
      force_b_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 32'd0;
      wait_cnt <= 4'd0;
      force_b  <= 1'b0;
    end else begin
      busy     <= busy_next;
      wait_cnt <= wait_cnt_next;
      force_b  <= force_b_next;
    end
  end

  // Registered view only: a clear in flight still shows as a hazard this cycle.
  always_comb begin
    hazard = ~rst & (busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]);
    pop    = 6'd0;
    for (int i = 0; i < 32; i++)
      pop = pop + 6'(busy[i]);
    busy_cnt = rst ? 6'd0 : pop;
  end

endmodule
